lut_config_loader: RTL

LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

---
 rtl/lut_config_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - shadow-buffered LUT configuration loader with atomic commit.
// Optional checksum word (CHECK state) enabled by defining LUT_CONFIG_LOADER_CHECKSUM_EN.
module lut_config_loader #(
    parameter int NUM_LUTS   = 4,
    parameter int CONF_WIDTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CONF_WIDTH-1:0]          data_in,
    input  logic                           data_valid,
    output logic                           data_ready,
    output logic [NUM_LUTS*CONF_WIDTH-1:0] conf_out,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int TOTAL_W = NUM_LUTS * CONF_WIDTH;
    localparam int IDX_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        ST_CHECK  = 2'd2,
`endif
        ST_COMMIT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   index;
    logic               load_full;
    logic [TOTAL_W-1:0] shadow;
    logic               accept;
    logic               commit;

`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
    logic [CONF_WIDTH-1:0] checksum;
    logic                  reject;

    always_comb begin
        checksum = '0;
        for (int k = 0; k < NUM_LUTS; k++) begin
            checksum = checksum ^ shadow[k*CONF_WIDTH +: CONF_WIDTH];
        end
    end
`else
    assign error = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

    // load_full holds LOAD for one extra cycle after the last word so the
    // commit lands two edges after the final accept.
    always_comb begin
        state_nxt  = state;
        commit     = 1'b0;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        reject     = 1'b0;
        data_ready = ((state == ST_LOAD) && !load_full) || (state == ST_CHECK);
`else
        data_ready = (state == ST_LOAD) && !load_full;
`endif
        accept     = data_valid && data_ready;

        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                if (load_full) state_nxt = ST_CHECK;
`else
                if (load_full) state_nxt = ST_COMMIT;
`endif
            end
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    if (data_in == checksum) begin
                        state_nxt = ST_COMMIT;
                    end else begin
                        state_nxt = ST_IDLE;
                        reject    = 1'b1;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            index     <= '0;
            load_full <= 1'b0;
            shadow    <= '0;
            conf_out  <= '0;
            done      <= 1'b0;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
            error     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= commit;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
            error <= reject;
`endif
            if ((state == ST_IDLE) && start) begin
                index     <= '0;
                load_full <= 1'b0;
            end else if ((state == ST_LOAD) && accept) begin
                shadow[index*CONF_WIDTH +: CONF_WIDTH] <= data_in;
                if (index == LAST_IDX) begin
                    load_full <= 1'b1;
                end else begin
                    index <= index + IDX_W'(1);
                end
            end
            // Whole-vector copy keeps partially loaded shadow contents invisible.
            if (commit) conf_out <= shadow;
        end
    end

endmodule
